// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage with a 2-entry skid buffer.
// The head register drives MEM and the skid register holds a second,
// younger entry. Both in_ready and out_valid are registered, so
// back-pressure from MEM never forms a combinational path back into EX.
// A synchronous flush kills held entries. A saturating counter records
// the cycles in which MEM stalls a valid head.
module ex_mem_skid_stage #(
   parameter int unsigned           DATA_W      = 64,
   parameter int unsigned           PC_W        = 32,
   parameter int unsigned           CNT_W       = 16,
   parameter logic [DATA_W-1:0]     RST_PAYLOAD = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_payload_i,
   input  logic [PC_W-1:0]   in_pc_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_payload_o,
   output logic [PC_W-1:0]   out_pc_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [1:0]        occupancy_o
);

   localparam logic [1:0]       OCC_EMPTY = 2'd0;
   localparam logic [1:0]       OCC_ONE   = 2'd1;
   localparam logic [1:0]       OCC_FULL  = 2'd2;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]        occ_q, occ_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic [DATA_W-1:0] head_q, head_d, skid_q, skid_d;
   logic [PC_W-1:0]   head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept_s, pop_s;

   assign accept_s = in_valid_i & in_ready_q;
   assign pop_s    = out_valid_q & out_ready_i;

   // State register: occupancy, head/skid storage, handshake flags and stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q       <= OCC_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         head_q      <= RST_PAYLOAD;
         head_pc_q   <= {PC_W{1'b0}};
         skid_q      <= {DATA_W{1'b0}};
         skid_pc_q   <= {PC_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
      end else begin
         occ_q       <= occ_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         head_q      <= head_d;
         head_pc_q   <= head_pc_d;
         skid_q      <= skid_d;
         skid_pc_q   <= skid_pc_d;
         cnt_q       <= cnt_d;
      end
   end

   // Next-state: FIFO occupancy transitions, with flush overriding any accept or pop.
   always_comb begin
      occ_d     = occ_q;
      head_d    = head_q;
      head_pc_d = head_pc_q;
      skid_d    = skid_q;
      skid_pc_d = skid_pc_q;
      if (flush_i) begin
         occ_d     = OCC_EMPTY;
         head_d    = RST_PAYLOAD;
         head_pc_d = {PC_W{1'b0}};
         skid_d    = {DATA_W{1'b0}};
         skid_pc_d = {PC_W{1'b0}};
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               if (accept_s) begin
                  occ_d     = OCC_ONE;
                  head_d    = in_payload_i;
                  head_pc_d = in_pc_i;
               end else begin
                  occ_d = OCC_EMPTY;
               end
            end
            OCC_ONE: begin
               if (accept_s && pop_s) begin
                  head_d    = in_payload_i;
                  head_pc_d = in_pc_i;
               end else if (accept_s) begin
                  occ_d     = OCC_FULL;
                  skid_d    = in_payload_i;
                  skid_pc_d = in_pc_i;
               end else if (pop_s) begin
                  occ_d = OCC_EMPTY;
               end else begin
                  occ_d = OCC_ONE;
               end
            end
            OCC_FULL: begin
               // in_ready is low here, so only a pop can move the state.
               if (pop_s) begin
                  occ_d     = OCC_ONE;
                  head_d    = skid_q;
                  head_pc_d = skid_pc_q;
               end else begin
                  occ_d = OCC_FULL;
               end
            end
            default: begin
               occ_d = OCC_EMPTY;
            end
         endcase
      end
   end

   // Next-state: registered handshake flags and the saturating stall counter.
   always_comb begin
      out_valid_d = (occ_d != OCC_EMPTY);
      in_ready_d  = (occ_d != OCC_FULL);
      if (!flush_i && out_valid_q && !out_ready_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Output: every port is driven straight from a register.
   always_comb begin
      in_ready_o    = in_ready_q;
      out_valid_o   = out_valid_q;
      out_payload_o = head_q;
      out_pc_o      = head_pc_q;
      stall_cnt_o   = cnt_q;
      occupancy_o   = occ_q;
   end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_ex_mem_skid_stage;

   localparam int unsigned DATA_W  = 64;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned CNT_W   = 4;
   localparam int          CNT_MAX = 15;
   localparam logic [DATA_W-1:0] RST_PL = 64'hDEAD_BEEF_CAFE_0001;

   typedef struct packed {
      logic [DATA_W-1:0] p;
      logic [PC_W-1:0]   pc;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush_i = 1'b0;
   logic              in_valid_i = 1'b0;
   logic              in_ready_o;
   logic [DATA_W-1:0] in_payload_i = '0;
   logic [PC_W-1:0]   in_pc_i = '0;
   logic              out_valid_o;
   logic              out_ready_i = 1'b0;
   logic [DATA_W-1:0] out_payload_o;
   logic [PC_W-1:0]   out_pc_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic [1:0]        occupancy_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   entry_t mq[$];
   int     mcnt = 0;
   bit     m_flushed = 1'b1;

   ex_mem_skid_stage #(
      .DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W), .RST_PAYLOAD(RST_PL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_payload_i(in_payload_i), .in_pc_i(in_pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_payload_o(out_payload_o), .out_pc_o(out_pc_o),
      .stall_cnt_o(stall_cnt_o), .occupancy_o(occupancy_o)
   );

   always #5 clk = ~clk;

   // Drive one cycle, let the edge happen, advance the model, sample 1 time unit later.
   task automatic drive_step(input logic v, input logic [DATA_W-1:0] p,
                             input logic [PC_W-1:0] pc, input logic rdy, input logic fl);
      bit acc, pp, stall;
      entry_t e;
      in_valid_i = v; in_payload_i = p; in_pc_i = pc; out_ready_i = rdy; flush_i = fl;
      acc   = v && (mq.size() < 2);
      pp    = (mq.size() != 0) && rdy;
      stall = (mq.size() != 0) && !rdy && !fl;
      @(posedge clk); #1;
      if (stall && mcnt != CNT_MAX) mcnt++;
      if (fl) begin
         mq.delete();
         m_flushed = 1'b1;
      end else begin
         if (pp) void'(mq.pop_front());
         if (acc) begin
            e.p = p; e.pc = pc;
            mq.push_back(e);
            m_flushed = 1'b0;
         end
      end
      flush_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      mq.delete(); mcnt = 0; m_flushed = 1'b1;
      in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      drive_step(1'b1, 64'h11, 32'h40, 1'b0, 1'b0);
      drive_step(1'b1, 64'h22, 32'h44, 1'b0, 1'b0);
      drive_step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (occupancy_o !== 2'd2 || stall_cnt_o === 4'd0) begin
         errors++;
         $display("FAIL reset_prefill: occ=%0d cnt=%0d, required occ=2 cnt>0", occupancy_o, stall_cnt_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || occupancy_o !== 2'd0 || stall_cnt_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_async_flags: valid=%b ready=%b occ=%0d cnt=%0d, required 0 1 0 0",
                  out_valid_o, in_ready_o, occupancy_o, stall_cnt_o);
      end
      checks++;
      if (out_payload_o !== RST_PL || out_pc_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_async_data: payload=%h pc=%h, required %h 0", out_payload_o, out_pc_o, RST_PL);
      end
      mq.delete(); mcnt = 0; m_flushed = 1'b1;
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_streaming();
      for (int k = 0; k < 9; k++) begin
         if (k < 8) drive_step(1'b1, 64'(k + 1), 32'(32'h100 + 4 * k), 1'b1, 1'b0);
         else       drive_step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
         checks++;
         if (k < 8) begin
            if (out_valid_o !== 1'b1 || out_payload_o !== 64'(k + 1) || out_pc_o !== 32'(32'h100 + 4 * k)) begin
               errors++;
               $display("FAIL stream_data[%0d]: valid=%b payload=%h pc=%h, required 1 %h %h",
                        k, out_valid_o, out_payload_o, out_pc_o, 64'(k + 1), 32'(32'h100 + 4 * k));
            end
         end else if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b, required 0", out_valid_o);
         end
         checks++;
         if (in_ready_o !== 1'b1 || stall_cnt_o !== 4'd0) begin
            errors++;
            $display("FAIL stream_flags[%0d]: ready=%b cnt=%0d, required 1 0", k, in_ready_o, stall_cnt_o);
         end
      end
   endtask

   task automatic test_backpressure();
      drive_step(1'b1, 64'hA, 32'h200, 1'b0, 1'b0);
      drive_step(1'b1, 64'hB, 32'h204, 1'b0, 1'b0);
      checks++;
      if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0 || out_payload_o !== 64'hA || stall_cnt_o !== 4'd1) begin
         errors++;
         $display("FAIL bp_full: occ=%0d ready=%b payload=%h cnt=%0d, required 2 0 a 1",
                  occupancy_o, in_ready_o, out_payload_o, stall_cnt_o);
      end
      for (int i = 0; i < 3; i++) begin
         drive_step(1'b1, 64'hEE, 32'h2EE, 1'b0, 1'b0);
         checks++;
         if (out_payload_o !== 64'hA || out_pc_o !== 32'h200 || occupancy_o !== 2'd2 || stall_cnt_o !== 4'(2 + i)) begin
            errors++;
            $display("FAIL bp_hold[%0d]: payload=%h pc=%h occ=%0d cnt=%0d, required a 200 2 %0d",
                     i, out_payload_o, out_pc_o, occupancy_o, stall_cnt_o, 2 + i);
         end
      end
      drive_step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (out_valid_o !== 1'b1 || out_payload_o !== 64'hB || out_pc_o !== 32'h204 || in_ready_o !== 1'b1 || stall_cnt_o !== 4'd4) begin
         errors++;
         $display("FAIL bp_release1: valid=%b payload=%h pc=%h ready=%b cnt=%0d, required 1 b 204 1 4",
                  out_valid_o, out_payload_o, out_pc_o, in_ready_o, stall_cnt_o);
      end
      drive_step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
         errors++;
         $display("FAIL bp_release2: valid=%b occ=%0d, required 0 0", out_valid_o, occupancy_o);
      end
   endtask

   task automatic test_flush();
      drive_step(1'b1, 64'h1, 32'h300, 1'b0, 1'b0);
      drive_step(1'b1, 64'h2, 32'h304, 1'b0, 1'b0);
      drive_step(1'b1, 64'hC, 32'h308, 1'b0, 1'b1);
      checks++;
      if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || in_ready_o !== 1'b1 ||
          out_payload_o !== RST_PL || out_pc_o !== 32'h0 || stall_cnt_o !== 4'd5) begin
         errors++;
         $display("FAIL flush_full: valid=%b occ=%0d ready=%b payload=%h pc=%h cnt=%0d, required 0 0 1 %h 0 5",
                  out_valid_o, occupancy_o, in_ready_o, out_payload_o, out_pc_o, stall_cnt_o, RST_PL);
      end
      for (int i = 0; i < 3; i++) begin
         drive_step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
         checks++;
         if (out_valid_o !== 1'b0 || out_payload_o === 64'hC) begin
            errors++;
            $display("FAIL flush_discard[%0d]: valid=%b payload=%h, required valid 0 and no c", i, out_valid_o, out_payload_o);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      drive_step(1'b1, 64'h55, 32'h400, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         drive_step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
         checks++;
         if (stall_cnt_o !== 4'((i > 15) ? 15 : i) || out_payload_o !== 64'h55) begin
            errors++;
            $display("FAIL sat[%0d]: cnt=%0d payload=%h, required %0d 55", i, stall_cnt_o, out_payload_o, (i > 15) ? 15 : i);
         end
      end
      drive_step(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (stall_cnt_o !== 4'd15) begin
         errors++;
         $display("FAIL sat_after_flush: cnt=%0d, required 15", stall_cnt_o);
      end
   endtask

   task automatic test_random();
      logic v, rdy, fl;
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         v   = ($urandom_range(0, 3) != 0);
         rdy = (c % 2000 < 1000) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 63) == 0);
         drive_step(v, {$urandom, $urandom}, $urandom, rdy, fl);
         checks++;
         if (out_valid_o !== (mq.size() != 0) || occupancy_o !== 2'(mq.size()) ||
             in_ready_o !== (mq.size() < 2) || stall_cnt_o !== 4'(mcnt)) begin
            errors++;
            $display("FAIL rand_flags[%0d]: valid=%b occ=%0d ready=%b cnt=%0d, required %b %0d %b %0d",
                     c, out_valid_o, occupancy_o, in_ready_o, stall_cnt_o,
                     (mq.size() != 0), mq.size(), (mq.size() < 2), mcnt);
         end
         if (mq.size() != 0) begin
            checks++;
            if (out_payload_o !== mq[0].p || out_pc_o !== mq[0].pc) begin
               errors++;
               $display("FAIL rand_head[%0d]: payload=%h pc=%h, required %h %h",
                        c, out_payload_o, out_pc_o, mq[0].p, mq[0].pc);
            end
         end else if (m_flushed) begin
            checks++;
            if (out_payload_o !== RST_PL || out_pc_o !== 32'h0) begin
               errors++;
               $display("FAIL rand_flushed[%0d]: payload=%h pc=%h, required %h 0", c, out_payload_o, out_pc_o, RST_PL);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
